// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv_ctrl_pkg : opcodes, field encodings, states and opcode classes   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package rv_ctrl_pkg;

   localparam logic [6:0] c_op_r      = 7'b0110011;
   localparam logic [6:0] c_op_imm    = 7'b0010011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_jal    = 7'b1101111;

   localparam logic [2:0] c_imm_i = 3'b000;
   localparam logic [2:0] c_imm_s = 3'b001;
   localparam logic [2:0] c_imm_b = 3'b010;
   localparam logic [2:0] c_imm_j = 3'b011;

   localparam logic [1:0] c_alu_add    = 2'b00;
   localparam logic [1:0] c_alu_sub    = 2'b01;
   localparam logic [1:0] c_alu_rfunct = 2'b10;
   localparam logic [1:0] c_alu_ifunct = 2'b11;

   localparam logic [2:0] c_st_fetch  = 3'd0;
   localparam logic [2:0] c_st_decode = 3'd1;
   localparam logic [2:0] c_st_exec   = 3'd2;
   localparam logic [2:0] c_st_mem    = 3'd3;
   localparam logic [2:0] c_st_wb     = 3'd4;
   localparam logic [2:0] c_st_trap   = 3'd7;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_IALU,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_JAL,
      CLS_ILLEGAL
   } op_class_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_ctrl_decode : combinational opcode -> instruction class          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mc_ctrl_decode
   import rv_ctrl_pkg::*;
#(
   parameter bit ENABLE_IALU = 1'b1,
   parameter bit ENABLE_JAL  = 1'b1
) (
   input  logic [6:0] opcode,
   output op_class_t  op_class
);

   // Disabled opcode groups fall through to ILLEGAL so they trap.
   always_comb begin
      op_class = CLS_ILLEGAL;
      case (opcode)
         c_op_r:      op_class = CLS_R;
         c_op_imm:    if (ENABLE_IALU) op_class = CLS_IALU;
         c_op_load:   op_class = CLS_LW;
         c_op_store:  op_class = CLS_SW;
         c_op_branch: op_class = CLS_BEQ;
         c_op_jal:    if (ENABLE_JAL) op_class = CLS_JAL;
         default:     op_class = CLS_ILLEGAL;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_control_unit : multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mc_control_unit
   import rv_ctrl_pkg::*;
#(
   parameter int IMMSEL_W    = 3,
   parameter bit ENABLE_IALU = 1'b1,
   parameter bit ENABLE_JAL  = 1'b1,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [6:0]          opcode,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                ir_write,
   output logic                pc_write,
   output logic [IMMSEL_W-1:0] immsel,
   output logic [1:0]          aluop,
   output logic                alusrc,
   output logic                MemtoReg,
   output logic                regwrite_en,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                Branch,
   output logic                Jump,
   output logic [2:0]          state_o,
   output logic                instr_done,
   output logic                illegal_op,
   output logic                mem_timeout
);

   localparam int c_cnt_w = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MEM_TIMEOUT);

   logic [2:0]         r_state;
   logic [2:0]         w_next_state;
   op_class_t          r_class;
   op_class_t          w_dec_class;
   logic [c_cnt_w-1:0] r_wait_cnt;
   logic               r_illegal;
   logic               r_timeout;
   logic               w_waiting;
   logic               w_expired;
   logic               w_enter_wait;

   mc_ctrl_decode #(
      .ENABLE_IALU (ENABLE_IALU),
      .ENABLE_JAL  (ENABLE_JAL)
   ) u_decode (
      .opcode   (opcode),
      .op_class (w_dec_class)
   );

   assign w_waiting    = (r_state == c_st_fetch) || (r_state == c_st_mem);
   // A ready on the terminal count still completes the access.
   assign w_expired    = (MEM_TIMEOUT > 0) && w_waiting && !mem_ready && (r_wait_cnt == c_cnt_max);
   assign w_enter_wait = (w_next_state != r_state) &&
                         ((w_next_state == c_st_fetch) || (w_next_state == c_st_mem));

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_fetch:  if (mem_ready) w_next_state = c_st_decode;
         c_st_decode: w_next_state = (w_dec_class == CLS_ILLEGAL) ? c_st_trap : c_st_exec;
         c_st_exec: begin
            case (r_class)
               CLS_R, CLS_IALU: w_next_state = c_st_wb;
               CLS_LW, CLS_SW:  w_next_state = c_st_mem;
               default:         w_next_state = c_st_fetch;
            endcase
         end
         c_st_mem:    if (mem_ready) w_next_state = (r_class == CLS_LW) ? c_st_wb : c_st_fetch;
         c_st_wb:     w_next_state = c_st_fetch;
         c_st_trap:   w_next_state = c_st_trap;
         default:     w_next_state = c_st_fetch;
      endcase
      if (w_expired) w_next_state = c_st_trap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_st_fetch;
         r_class    <= CLS_ILLEGAL;
         r_wait_cnt <= '0;
         r_illegal  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == c_st_decode) r_class <= w_dec_class;
         if (mem_ready || w_enter_wait)
            r_wait_cnt <= '0;
         else if ((MEM_TIMEOUT > 0) && w_waiting && !w_expired)
            r_wait_cnt <= r_wait_cnt + 1'b1;
         // TRAP is absorbing, so whichever flag fires first is the only one set.
         if ((r_state == c_st_decode) && (w_dec_class == CLS_ILLEGAL)) r_illegal <= 1'b1;
         if (w_expired) r_timeout <= 1'b1;
      end
   end

   assign state_o     = r_state;
   assign illegal_op  = r_illegal;
   assign mem_timeout = r_timeout;

   // Held at zero during reset so an in-flight store is abandoned immediately.
   always_comb begin
      mem_req     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      immsel      = '0;
      aluop       = c_alu_add;
      alusrc      = 1'b0;
      MemtoReg    = 1'b0;
      regwrite_en = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      Branch      = 1'b0;
      Jump        = 1'b0;
      instr_done  = 1'b0;
      if (!rst) begin
         case (r_state)
            c_st_fetch: begin
               mem_req  = 1'b1;
               MemRead  = 1'b1;
               ir_write = mem_ready;
               pc_write = mem_ready;
            end
            c_st_exec: begin
               case (r_class)
                  CLS_R: aluop = c_alu_rfunct;
                  CLS_IALU: begin
                     aluop  = c_alu_ifunct;
                     alusrc = 1'b1;
                     immsel = IMMSEL_W'(c_imm_i);
                  end
                  CLS_LW: begin
                     alusrc = 1'b1;
                     immsel = IMMSEL_W'(c_imm_i);
                  end
                  CLS_SW: begin
                     alusrc = 1'b1;
                     immsel = IMMSEL_W'(c_imm_s);
                  end
                  CLS_BEQ: begin
                     aluop      = c_alu_sub;
                     immsel     = IMMSEL_W'(c_imm_b);
                     Branch     = 1'b1;
                     instr_done = 1'b1;
                  end
                  CLS_JAL: begin
                     immsel      = IMMSEL_W'(c_imm_j);
                     Jump        = 1'b1;
                     pc_write    = 1'b1;
                     regwrite_en = 1'b1;
                     instr_done  = 1'b1;
                  end
                  default: ;
               endcase
            end
            c_st_mem: begin
               mem_req    = 1'b1;
               MemRead    = (r_class == CLS_LW);
               MemWrite   = (r_class == CLS_SW);
               instr_done = (r_class == CLS_SW) && mem_ready;
            end
            c_st_wb: begin
               regwrite_en = 1'b1;
               MemtoReg    = (r_class == CLS_LW);
               instr_done  = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mc_control_unit : directed checks, default build plus a build    |
// | with OP-IMM disabled and MEM_TIMEOUT=4.  Rev 1.0                    |
// +--------------------------------------------------------------------+
module tb_mc_control_unit;

   localparam logic [6:0] OP_ADD = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [6:0] opcode;
   logic       mem_ready;

   logic       a_mem_req, a_ir_write, a_pc_write, a_alusrc, a_MemtoReg, a_regwrite_en;
   logic       a_MemRead, a_MemWrite, a_Branch, a_Jump, a_instr_done, a_illegal_op, a_mem_timeout;
   logic [2:0] a_immsel, a_state;
   logic [1:0] a_aluop;

   logic       b_mem_req, b_ir_write, b_pc_write, b_alusrc, b_MemtoReg, b_regwrite_en;
   logic       b_MemRead, b_MemWrite, b_Branch, b_Jump, b_instr_done, b_illegal_op, b_mem_timeout;
   logic [2:0] b_immsel, b_state;
   logic [1:0] b_aluop;

   int total = 0;
   int bad   = 0;
   int pulses;
   logic flag;

   always #5 clk = ~clk;

   mc_control_unit dut_a (
      .clk(clk), .rst(rst_a), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(a_mem_req), .ir_write(a_ir_write), .pc_write(a_pc_write), .immsel(a_immsel),
      .aluop(a_aluop), .alusrc(a_alusrc), .MemtoReg(a_MemtoReg), .regwrite_en(a_regwrite_en),
      .MemRead(a_MemRead), .MemWrite(a_MemWrite), .Branch(a_Branch), .Jump(a_Jump),
      .state_o(a_state), .instr_done(a_instr_done), .illegal_op(a_illegal_op),
      .mem_timeout(a_mem_timeout)
   );

   mc_control_unit #(.IMMSEL_W(3), .ENABLE_IALU(1'b0), .ENABLE_JAL(1'b1), .MEM_TIMEOUT(4)) dut_b (
      .clk(clk), .rst(rst_b), .opcode(opcode), .mem_ready(mem_ready),
      .mem_req(b_mem_req), .ir_write(b_ir_write), .pc_write(b_pc_write), .immsel(b_immsel),
      .aluop(b_aluop), .alusrc(b_alusrc), .MemtoReg(b_MemtoReg), .regwrite_en(b_regwrite_en),
      .MemRead(b_MemRead), .MemWrite(b_MemWrite), .Branch(b_Branch), .Jump(b_Jump),
      .state_o(b_state), .instr_done(b_instr_done), .illegal_op(b_illegal_op),
      .mem_timeout(b_mem_timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Next cycle: inputs change just after the falling edge, outputs are read 1 unit later.
   task automatic cyc(input logic r, input logic [6:0] o);
      @(negedge clk);
      mem_ready = r;
      opcode    = o;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; opcode = OP_ADD; mem_ready = 1'b0;
      #12;
      check("rst_state",    a_state, 0);
      check("rst_mem_req",  a_mem_req, 0);
      check("rst_memread",  a_MemRead, 0);
      check("rst_illegal",  a_illegal_op, 0);
      check("rst_timeout",  a_mem_timeout, 0);

      // add
      @(negedge clk); rst_a = 1'b0; mem_ready = 1'b1; opcode = OP_ADD; #1;
      pulses = 0;
      check("add_f_state",   a_state, 0);
      check("add_f_mem_req", a_mem_req, 1);
      check("add_f_memread", a_MemRead, 1);
      check("add_f_irwrite", a_ir_write, 1);
      check("add_f_pcwrite", a_pc_write, 1);
      check("add_f_regwr",   a_regwrite_en, 0);
      pulses += int'(a_instr_done);
      cyc(1'b1, OP_ADD);
      check("add_d_state",   a_state, 1);
      check("add_d_regwr",   a_regwrite_en, 0);
      pulses += int'(a_instr_done);
      cyc(1'b1, OP_ADD);
      check("add_e_state",   a_state, 2);
      check("add_e_aluop",   a_aluop, 2'b10);
      check("add_e_alusrc",  a_alusrc, 0);
      check("add_e_regwr",   a_regwrite_en, 0);
      pulses += int'(a_instr_done);
      cyc(1'b1, OP_ADD);
      check("add_w_state",   a_state, 4);
      check("add_w_regwr",   a_regwrite_en, 1);
      check("add_w_memtoreg", a_MemtoReg, 0);
      pulses += int'(a_instr_done);
      check("add_done_pulses", pulses, 1);

      // addi
      cyc(1'b1, OP_IMM);
      check("imm_f_state",   a_state, 0);
      check("imm_f_done",    a_instr_done, 0);
      cyc(1'b1, OP_IMM);
      cyc(1'b1, OP_IMM);
      check("imm_e_state",   a_state, 2);
      check("imm_e_aluop",   a_aluop, 2'b11);
      check("imm_e_alusrc",  a_alusrc, 1);
      check("imm_e_immsel",  a_immsel, 3'b000);
      cyc(1'b1, OP_IMM);
      check("imm_w_state",   a_state, 4);
      check("imm_w_regwr",   a_regwrite_en, 1);

      // lw with three wait cycles in MEM
      cyc(1'b1, OP_LW);
      check("lw_f_state",    a_state, 0);
      cyc(1'b1, OP_LW);
      cyc(1'b1, OP_LW);
      check("lw_e_aluop",    a_aluop, 2'b00);
      check("lw_e_alusrc",   a_alusrc, 1);
      flag = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, OP_LW);
         if (a_state !== 3'd3 || a_mem_req !== 1'b1 || a_MemRead !== 1'b1 ||
             a_MemWrite !== 1'b0 || a_instr_done !== 1'b0) flag = 1'b1;
      end
      check("lw_mem_hold",   flag, 0);
      cyc(1'b1, OP_LW);
      check("lw_m4_state",   a_state, 3);
      check("lw_m4_mem_req", a_mem_req, 1);
      check("lw_m4_done",    a_instr_done, 0);
      cyc(1'b1, OP_LW);
      check("lw_w_state",    a_state, 4);
      check("lw_w_memtoreg", a_MemtoReg, 1);
      check("lw_w_regwr",    a_regwrite_en, 1);
      check("lw_w_done",     a_instr_done, 1);

      // sw (ready low in DECODE/EXEC is ignored) then beq
      cyc(1'b1, OP_SW);
      check("sw_f_state",    a_state, 0);
      cyc(1'b0, OP_SW);
      check("sw_d_state",    a_state, 1);
      cyc(1'b0, OP_SW);
      check("sw_e_state",    a_state, 2);
      check("sw_e_immsel",   a_immsel, 3'b001);
      check("sw_e_memwrite", a_MemWrite, 0);
      cyc(1'b1, OP_SW);
      check("sw_m_state",    a_state, 3);
      check("sw_m_memwrite", a_MemWrite, 1);
      check("sw_m_memread",  a_MemRead, 0);
      check("sw_m_done",     a_instr_done, 1);
      cyc(1'b1, OP_BEQ);
      check("beq_f_state",   a_state, 0);
      check("beq_f_memwrite", a_MemWrite, 0);
      cyc(1'b1, OP_BEQ);
      cyc(1'b1, OP_BEQ);
      check("beq_e_state",   a_state, 2);
      check("beq_e_branch",  a_Branch, 1);
      check("beq_e_immsel",  a_immsel, 3'b010);
      check("beq_e_aluop",   a_aluop, 2'b01);
      check("beq_e_done",    a_instr_done, 1);

      // jal
      cyc(1'b1, OP_JAL);
      check("jal_f_state",   a_state, 0);
      cyc(1'b1, OP_JAL);
      cyc(1'b1, OP_JAL);
      check("jal_e_jump",    a_Jump, 1);
      check("jal_e_pcwrite", a_pc_write, 1);
      check("jal_e_regwr",   a_regwrite_en, 1);
      check("jal_e_immsel",  a_immsel, 3'b011);
      check("jal_e_done",    a_instr_done, 1);

      // illegal opcode, with one stalled fetch cycle first
      cyc(1'b0, OP_BAD);
      check("ill_stall_state", a_state, 0);
      check("ill_stall_irw",   a_ir_write, 0);
      cyc(1'b1, OP_BAD);
      check("ill_f_irwrite", a_ir_write, 1);
      cyc(1'b1, OP_BAD);
      check("ill_d_state",   a_state, 1);
      check("ill_d_flag",    a_illegal_op, 0);
      cyc(1'b1, OP_BAD);
      check("ill_t_state",   a_state, 7);
      check("ill_t_flag",    a_illegal_op, 1);
      check("ill_t_mem_req", a_mem_req, 0);
      flag = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'(i % 2), OP_ADD);
         if (a_state !== 3'd7 || a_regwrite_en !== 1'b0 || a_MemWrite !== 1'b0 ||
             a_mem_req !== 1'b0 || a_illegal_op !== 1'b1 || a_mem_timeout !== 1'b0) flag = 1'b1;
      end
      check("ill_trap_hold", flag, 0);

      // reset clears the sticky flag, then asynchronous reset mid-MEM of sw
      rst_a = 1'b1; #1;
      check("rerst_illegal", a_illegal_op, 0);
      check("rerst_state",   a_state, 0);
      @(negedge clk); rst_a = 1'b0; mem_ready = 1'b1; opcode = OP_SW; #1;
      cyc(1'b1, OP_SW);
      cyc(1'b1, OP_SW);
      cyc(1'b0, OP_SW);
      check("arst_pre_memwrite", a_MemWrite, 1);
      check("arst_pre_mem_req",  a_mem_req, 1);
      #2 rst_a = 1'b1; #1;
      check("arst_memwrite", a_MemWrite, 0);
      check("arst_mem_req",  a_mem_req, 0);
      check("arst_state",    a_state, 0);

      // OP-IMM disabled build: addi traps
      @(negedge clk); rst_b = 1'b0; mem_ready = 1'b1; opcode = OP_IMM; #1;
      cyc(1'b1, OP_IMM);
      check("b_imm_d_state", b_state, 1);
      cyc(1'b1, OP_IMM);
      check("b_imm_state",   b_state, 7);
      check("b_imm_illegal", b_illegal_op, 1);
      check("b_imm_timeout", b_mem_timeout, 0);
      rst_b = 1'b1; #1;
      check("b_rerst_illegal", b_illegal_op, 0);

      // fetch never ready: fifth stalled cycle leads to TRAP
      @(negedge clk); rst_b = 1'b0; mem_ready = 1'b0; opcode = OP_ADD; #1;
      for (int i = 0; i < 4; i++) cyc(1'b0, OP_ADD);
      check("to_pre_state",   b_state, 0);
      check("to_pre_timeout", b_mem_timeout, 0);
      cyc(1'b0, OP_ADD);
      check("to_state",       b_state, 7);
      check("to_timeout",     b_mem_timeout, 1);
      check("to_illegal",     b_illegal_op, 0);
      check("to_mem_req",     b_mem_req, 0);

      // ready arrives on the terminal count: no timeout
      rst_b = 1'b1; #1;
      check("to_rerst_timeout", b_mem_timeout, 0);
      @(negedge clk); rst_b = 1'b0; mem_ready = 1'b0; opcode = OP_ADD; #1;
      for (int i = 0; i < 3; i++) cyc(1'b0, OP_ADD);
      cyc(1'b1, OP_ADD);
      check("edge_f_state",   b_state, 0);
      check("edge_f_irwrite", b_ir_write, 1);
      cyc(1'b1, OP_ADD);
      check("edge_state",     b_state, 1);
      check("edge_timeout",   b_mem_timeout, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
